// File: rtl/mips_prog_loader.sv
// Boot-time program loader for the multicycle 8-bit MIPS core.
// Takes a length-prefixed, checksummed byte stream, writes the payload
// into program memory and holds the core in reset until the image is
// verified, then releases it after a short fixed hold interval.
//
// Stream format: L, d[0] .. d[L-1], c   where (d[0]+..+d[L-1]+c) mod 256 == 0.
//
// Handshake: a byte moves on a rising ph1 edge where in_valid && in_ready.
// in_ready is a register computed from the next state, so it is already low
// in the first HOLD/FAIL cycle and low in the first cycle after reset.
//
// dbg_state encoding: 0 WAIT_LEN, 1 LOAD, 2 CHECK, 3 HOLD, 4 RUN, 5 FAIL.
module mips_prog_loader #(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         HOLD_CYCLES = 2
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_reset,
  output logic       done,
  output logic       error,
  output logic [7:0] byte_count,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT_LEN = 3'd0,
    S_LOAD     = 3'd1,
    S_CHECK    = 3'd2,
    S_HOLD     = 3'd3,
    S_RUN      = 3'd4,
    S_FAIL     = 3'd5
  } state_t;

  // Last value of the hold counter before leaving HOLD.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_len;
  logic [7:0] r_sum;
  logic [3:0] r_hold;
  logic [7:0] r_count;
  logic       r_in_ready;
  logic       r_mem_we;
  logic [7:0] r_mem_addr;
  logic [7:0] r_mem_wdata;
  logic       r_cpu_reset;
  logic       r_done;
  logic       r_error;

  state_t     w_next_state;
  logic [7:0] w_next_len;
  logic [7:0] w_next_sum;
  logic [3:0] w_next_hold;
  logic [7:0] w_next_count;
  logic       w_load_write;
  logic       w_xfer;
  logic [7:0] w_sum_add;
  logic [7:0] w_count_inc;

  assign w_xfer      = in_valid & r_in_ready;
  assign w_sum_add   = r_sum + in_data;
  assign w_count_inc = r_count + 8'd1;

  // Next-state and datapath-update decode for the loader FSM.
  always_comb begin
    w_next_state = r_state;
    w_next_len   = r_len;
    w_next_sum   = r_sum;
    w_next_hold  = r_hold;
    w_next_count = r_count;
    w_load_write = 1'b0;
    case (r_state)
      S_WAIT_LEN: begin
        if (w_xfer) begin
          w_next_len = in_data;
          if (in_data == 8'd0) begin
            w_next_state = S_FAIL;
          end else begin
            w_next_sum   = 8'd0;
            w_next_state = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_load_write = 1'b1;
          w_next_sum   = w_sum_add;
          w_next_count = w_count_inc;
          if (w_count_inc == r_len) begin
            w_next_state = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (w_xfer) begin
          if (w_sum_add == 8'd0) begin
            w_next_hold  = 4'd0;
            w_next_state = S_HOLD;
          end else begin
            w_next_state = S_FAIL;
          end
        end
      end
      S_HOLD: begin
        if (r_hold == HOLD_LAST) begin
          w_next_state = S_RUN;
        end else begin
          w_next_hold = r_hold + 4'd1;
        end
      end
      S_RUN:   w_next_state = S_RUN;
      S_FAIL:  w_next_state = S_FAIL;
      default: w_next_state = S_FAIL;
    endcase
  end

  // FSM state and the length/sum/count/hold bookkeeping registers.
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state <= S_WAIT_LEN;
      r_len   <= 8'd0;
      r_sum   <= 8'd0;
      r_hold  <= 4'd0;
      r_count <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_len   <= w_next_len;
      r_sum   <= w_next_sum;
      r_hold  <= w_next_hold;
      r_count <= w_next_count;
    end
  end

  // Program-memory write port: one strobe per accepted payload byte,
  // address/data hold their last values while the strobe is low.
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= 8'd0;
    end else begin
      r_mem_we <= w_load_write;
      if (w_load_write) begin
        r_mem_addr  <= BASE_ADDR + r_count;
        r_mem_wdata <= in_data;
      end
    end
  end

  // Handshake and status flags. cpu_reset/done follow the registered state,
  // so the core is released one cycle after the FSM reaches RUN; error rises
  // together with entry into FAIL.
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_in_ready  <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == S_WAIT_LEN) ||
                     (w_next_state == S_LOAD) ||
                     (w_next_state == S_CHECK);
      r_cpu_reset <= (r_state != S_RUN);
      r_done      <= (r_state == S_RUN);
      r_error     <= (w_next_state == S_FAIL);
    end
  end

  assign in_ready   = r_in_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;
  assign byte_count = r_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader. Two loaders share one input stream:
// u_dut at BASE_ADDR 8'h00 and u_wrap at BASE_ADDR 8'hFE, so every image
// also exercises the address wrap on the second instance.
module tb_mips_prog_loader;

  // ---------------- clock / reset ----------------
  logic       ph1      = 1'b0;
  logic       reset    = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;

  always #5 ph1 = ~ph1;

  logic       a_in_ready, a_mem_we, a_cpu_reset, a_done, a_error;
  logic [7:0] a_mem_addr, a_mem_wdata, a_byte_count;
  logic [2:0] a_dbg_state;
  logic       b_in_ready, b_mem_we, b_cpu_reset, b_done, b_error;
  logic [7:0] b_mem_addr, b_mem_wdata, b_byte_count;
  logic [2:0] b_dbg_state;

  mips_prog_loader #(.BASE_ADDR(8'h00), .HOLD_CYCLES(2)) u_dut (
    .ph1(ph1), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .cpu_reset(a_cpu_reset), .done(a_done),
    .error(a_error), .byte_count(a_byte_count), .dbg_state(a_dbg_state)
  );

  mips_prog_loader #(.BASE_ADDR(8'hFE), .HOLD_CYCLES(2)) u_wrap (
    .ph1(ph1), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .cpu_reset(b_cpu_reset), .done(b_done),
    .error(b_error), .byte_count(b_byte_count), .dbg_state(b_dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- scoreboard ----------------
  // Expected writes as {addr, data}, one queue per instance.
  logic [15:0] exp_q[$];
  logic [15:0] exp_wrap_q[$];

  always @(negedge ph1) begin
    logic [15:0] e;
    if (a_mem_we) begin
      e = 16'hxxxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      n_vec++;
      assert ({a_mem_addr, a_mem_wdata} === e) else begin
        n_err++;
        $error("FAIL write_base: observed %h expected %h", {a_mem_addr, a_mem_wdata}, e);
      end
    end
    if (b_mem_we) begin
      e = 16'hxxxx;
      if (exp_wrap_q.size() > 0) e = exp_wrap_q.pop_front();
      n_vec++;
      assert ({b_mem_addr, b_mem_wdata} === e) else begin
        n_err++;
        $error("FAIL write_wrap: observed %h expected %h", {b_mem_addr, b_mem_wdata}, e);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge ph1);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_write(input logic [7:0] idx, input logic [7:0] data);
    logic [7:0] wa;
    wa = 8'hFE + idx;
    exp_q.push_back({idx, data});
    exp_wrap_q.push_back({wa, data});
  endtask

  // Presents a byte and returns #1 after the edge that accepted it.
  // in_valid is left high so consecutive calls stream back-to-back.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (a_in_ready !== 1'b1 && waited < 20) begin
      tick(1);
      waited++;
    end
    n_vec++;
    assert (a_in_ready === 1'b1) else begin
      n_err++;
      $error("FAIL send_timeout: in_ready observed %b expected 1 for byte %h", a_in_ready, b);
    end
    tick(1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    if (n > 0) tick(n);
  endtask

  task automatic do_reset();
    n_vec++;
    assert (exp_q.size() == 0 && exp_wrap_q.size() == 0) else begin
      n_err++;
      $error("FAIL writes_missing: observed %0d/%0d pending expected 0", exp_q.size(), exp_wrap_q.size());
    end
    exp_q.delete();
    exp_wrap_q.delete();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick(2);
    chk1("rst_in_ready",   a_in_ready,   1'b0);
    chk1("rst_mem_we",     a_mem_we,     1'b0);
    chk8("rst_mem_addr",   a_mem_addr,   8'h00);
    chk8("rst_wrap_addr",  b_mem_addr,   8'hFE);
    chk8("rst_mem_wdata",  a_mem_wdata,  8'h00);
    chk1("rst_cpu_reset",  a_cpu_reset,  1'b1);
    chk1("rst_done",       a_done,       1'b0);
    chk1("rst_error",      a_error,      1'b0);
    chk8("rst_byte_count", a_byte_count, 8'h00);
    chk8("rst_state",      {5'd0, a_dbg_state}, 8'd0);
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Normal load: 03 20 08 00 D8 (0x28 + 0xD8 = 0x100).
    do_reset();
    send_byte(8'h03);
    chk1("norm_len_no_we", a_mem_we, 1'b0);
    expect_write(8'd0, 8'h20);
    send_byte(8'h20);
    chk1("norm_we0", a_mem_we, 1'b1);
    chk8("norm_addr0", a_mem_addr, 8'h00);
    chk8("norm_data0", a_mem_wdata, 8'h20);
    chk8("norm_cnt1", a_byte_count, 8'd1);
    expect_write(8'd1, 8'h08);
    send_byte(8'h08);
    chk1("norm_we1", a_mem_we, 1'b1);
    chk8("norm_addr1", a_mem_addr, 8'h01);
    expect_write(8'd2, 8'h00);
    send_byte(8'h00);
    chk1("norm_we2", a_mem_we, 1'b1);
    chk8("norm_addr2", a_mem_addr, 8'h02);
    chk8("norm_data2", a_mem_wdata, 8'h00);
    chk8("norm_cnt3", a_byte_count, 8'd3);
    send_byte(8'hD8);
    idle(0);
    chk1("norm_ck_no_we", a_mem_we, 1'b0);
    chk1("norm_hold_ready", a_in_ready, 1'b0);
    chk1("norm_hold_rst0", a_cpu_reset, 1'b1);
    tick(1);
    chk1("norm_hold_rst1", a_cpu_reset, 1'b1);
    tick(1);
    chk1("norm_hold_rst2", a_cpu_reset, 1'b1);
    chk1("norm_hold_done", a_done, 1'b0);
    tick(1);
    chk1("norm_release", a_cpu_reset, 1'b0);
    chk1("norm_done", a_done, 1'b1);
    chk1("norm_error", a_error, 1'b0);
    chk8("norm_cnt_final", a_byte_count, 8'd3);
    chk8("norm_state_run", {5'd0, a_dbg_state}, 8'd4);
    chk1("norm_wrap_done", b_done, 1'b1);
    tick(2);
    chk1("norm_done_sticky", a_done, 1'b1);

    // Bad checksum: 03 20 08 00 D7 (sum 0xFF).
    do_reset();
    expect_write(8'd0, 8'h20);
    expect_write(8'd1, 8'h08);
    expect_write(8'd2, 8'h00);
    send_byte(8'h03);
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'hD7);
    chk1("bad_error", a_error, 1'b1);
    chk1("bad_ready", a_in_ready, 1'b0);
    tick(4);
    chk1("bad_error_sticky", a_error, 1'b1);
    chk1("bad_cpu_reset", a_cpu_reset, 1'b1);
    chk1("bad_done", a_done, 1'b0);
    chk1("bad_ready_late", a_in_ready, 1'b0);
    chk8("bad_state_fail", {5'd0, a_dbg_state}, 8'd5);
    idle(0);

    // Zero length.
    do_reset();
    send_byte(8'h00);
    idle(0);
    chk1("zero_error", a_error, 1'b1);
    chk1("zero_ready", a_in_ready, 1'b0);
    chk1("zero_no_we", a_mem_we, 1'b0);
    tick(3);
    chk1("zero_no_we_late", a_mem_we, 1'b0);
    chk1("zero_cpu_reset", a_cpu_reset, 1'b1);
    chk8("zero_cnt", a_byte_count, 8'd0);

    // Stalled stream: 02 .. 11 .. 22 CD (0x33 + 0xCD = 0x100).
    do_reset();
    send_byte(8'h02);
    idle(0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk1("stall_a_no_we", a_mem_we, 1'b0);
    end
    chk8("stall_a_cnt", a_byte_count, 8'd0);
    expect_write(8'd0, 8'h11);
    send_byte(8'h11);
    chk1("stall_we0", a_mem_we, 1'b1);
    chk8("stall_addr0", a_mem_addr, 8'h00);
    idle(0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk1("stall_b_no_we", a_mem_we, 1'b0);
    end
    chk8("stall_b_addr_hold", a_mem_addr, 8'h00);
    chk8("stall_b_cnt", a_byte_count, 8'd1);
    expect_write(8'd1, 8'h22);
    send_byte(8'h22);
    chk1("stall_we1", a_mem_we, 1'b1);
    chk8("stall_addr1", a_mem_addr, 8'h01);
    send_byte(8'hCD);
    idle(3);
    chk1("stall_done", a_done, 1'b1);
    chk1("stall_release", a_cpu_reset, 1'b0);

    // Address wrap: 03 01 02 03 FA, checked on the 8'hFE instance.
    do_reset();
    send_byte(8'h03);
    expect_write(8'd0, 8'h01);
    send_byte(8'h01);
    chk8("wrap_addr_fe", b_mem_addr, 8'hFE);
    chk8("wrap_base_addr0", a_mem_addr, 8'h00);
    expect_write(8'd1, 8'h02);
    send_byte(8'h02);
    chk8("wrap_addr_ff", b_mem_addr, 8'hFF);
    expect_write(8'd2, 8'h03);
    send_byte(8'h03);
    chk8("wrap_addr_00", b_mem_addr, 8'h00);
    chk8("wrap_data_03", b_mem_wdata, 8'h03);
    send_byte(8'hFA);
    idle(3);
    chk1("wrap_done", b_done, 1'b1);
    chk1("wrap_base_done", a_done, 1'b1);

    // Reset after two of three data bytes, then a full image.
    do_reset();
    send_byte(8'h03);
    expect_write(8'd0, 8'h20);
    send_byte(8'h20);
    expect_write(8'd1, 8'h08);
    send_byte(8'h08);
    reset    = 1'b1;
    in_valid = 1'b0;
    tick(1);
    chk8("mid_rst_cnt", a_byte_count, 8'd0);
    chk1("mid_rst_cpu_reset", a_cpu_reset, 1'b1);
    chk1("mid_rst_ready", a_in_ready, 1'b0);
    do_reset();
    send_byte(8'h03);
    expect_write(8'd0, 8'h20);
    send_byte(8'h20);
    chk8("mid_reload_addr0", a_mem_addr, 8'h00);
    chk8("mid_reload_cnt1", a_byte_count, 8'd1);
    expect_write(8'd1, 8'h08);
    send_byte(8'h08);
    expect_write(8'd2, 8'h00);
    send_byte(8'h00);
    send_byte(8'hD8);
    idle(3);
    chk1("mid_done", a_done, 1'b1);
    chk1("mid_release", a_cpu_reset, 1'b0);
    chk1("mid_error", a_error, 1'b0);

    // All expected writes must have been seen.
    n_vec++;
    assert (exp_q.size() == 0 && exp_wrap_q.size() == 0) else begin
      n_err++;
      $error("FAIL writes_missing_end: observed %0d/%0d pending expected 0", exp_q.size(), exp_wrap_q.size());
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
